// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled asynchronous serial receiver, LSB first.
// Optional even-parity check is compiled in by defining UART_RX_PARITY_EN;
// without it the parity state is absent and o_parity_err is tied low.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line idle, waiting for rx_s to fall
// START  | counting to the middle of the start bit to confirm it
// DATA   | sampling NB_DATA data bits at bit centres
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | waiting out the stop bit(s), then publishing the frame
module uart_rx #(
  parameter int NB_DATA = 8,
  parameter int SB_TICK = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_s_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done_tick,
  output logic               o_frame_err,
  output logic               o_parity_err
);

  // tick counter must reach SB_TICK-1 in STOP, so it grows past 4 bits for long stops
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = $clog2(NB_DATA);

  localparam logic [SW-1:0] S_MID      = SW'(7);
  localparam logic [SW-1:0] S_BIT_END  = SW'(15);
  localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST     = NW'(NB_DATA - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam state_t DATA_EXIT = PARITY;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
  localparam state_t DATA_EXIT = STOP;
`endif

  state_t             state;
  logic [SW-1:0]      s;
  logic [NW-1:0]      n;
  logic [NB_DATA-1:0] shreg;
  logic               rx_meta;
  logic               rx_s;

`ifdef UART_RX_PARITY_EN
  logic               par_bit;
`else
  assign o_parity_err = 1'b0;
`endif

  // two-flop synchronizer on the asynchronous line; both stages reset to idle-high
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // receive FSM with registered outputs; everything but start detection waits for a tick
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= IDLE;
      s              <= '0;
      n              <= '0;
      shreg          <= '0;
      o_data         <= '0;
      o_rx_done_tick <= 1'b0;
      o_frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit        <= 1'b0;
      o_parity_err   <= 1'b0;
`endif
    end else begin
      o_rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (i_s_tick) begin
            if (s == S_MID) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (i_s_tick) begin
            if (s == S_BIT_END) begin
              s     <= '0;
              shreg <= {rx_s, shreg[NB_DATA-1:1]};
              if (n == N_LAST) begin
                state <= DATA_EXIT;
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (i_s_tick) begin
            if (s == S_BIT_END) begin
              par_bit <= rx_s;
              state   <= STOP;
              s       <= '0;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (i_s_tick) begin
            if (s == S_STOP_END) begin
              state          <= IDLE;
              o_data         <= shreg;
              o_frame_err    <= ~rx_s;
              o_rx_done_tick <= 1'b1;
`ifdef UART_RX_PARITY_EN
              o_parity_err   <= ^{shreg, par_bit};
`endif
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
